// File: rtl/tc_control_unit.sv
// Sequencing control for the dense tensor-core datapath: after an optional load
// phase, walks (row m, N-tile n, K-tile k) and pulses out_valid per finished row.
module tc_control_unit #(
    parameter int M      = 16,
    parameter int N      = 16,
    parameter int K      = 16,
    parameter int tileN  = 4,
    parameter int tileK  = 4,
    parameter int iterN  = N / tileN,
    parameter int iterK  = K / tileK,
    parameter int DW_ROW = 4,
    parameter int DW_COL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              compute_en,
    output logic [DW_ROW-1:0] ptr_m,
    output logic [DW_COL-1:0] ptr_n,
    output logic [DW_COL-1:0] ptr_k,
    output logic              out_valid,
    output logic [DW_ROW-1:0] row_out
);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE} state_t;

    localparam logic [DW_ROW-1:0] M_LAST = DW_ROW'(M - 1);
    localparam logic [DW_COL-1:0] N_LAST = DW_COL'(iterN - 1);
    localparam logic [DW_COL-1:0] K_LAST = DW_COL'(iterK - 1);

    state_t            state_q, state_d;
    logic [DW_ROW-1:0] m_q, m_d;
    logic [DW_COL-1:0] n_q, n_d;
    logic [DW_COL-1:0] k_q, k_d;
    logic              out_valid_q, out_valid_d;
    logic [DW_ROW-1:0] row_out_q, row_out_d;
    logic              row_end;

    assign row_end = (n_q == N_LAST) && (k_q == K_LAST);

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        n_d         = n_q;
        k_d         = k_q;
        out_valid_d = 1'b0;
        row_out_d   = row_out_q;
        case (state_q)
            IDLE: begin
                m_d = '0;
                n_d = '0;
                k_d = '0;
                if (load_en)
                    state_d = LOAD;
                else if (compute_en)
                    state_d = COMPUTE;
            end
            LOAD: begin
                m_d = '0;
                n_d = '0;
                k_d = '0;
                if (!load_en)
                    state_d = IDLE;
            end
            COMPUTE: begin
                // Pulse lands one cycle after the row's last tile step.
                if (row_end) begin
                    out_valid_d = 1'b1;
                    row_out_d   = m_q;
                end
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (n_q == N_LAST) begin
                        n_d = '0;
                        if (m_q == M_LAST) begin
                            m_d     = '0;
                            state_d = IDLE;
                        end else begin
                            m_d = m_q + 1'b1;
                        end
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                m_d     = '0;
                n_d     = '0;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            m_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            row_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            n_q         <= n_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            row_out_q   <= row_out_d;
        end
    end

    assign ptr_m     = m_q;
    assign ptr_n     = n_q;
    assign ptr_k     = k_q;
    assign out_valid = out_valid_q;
    assign row_out   = row_out_q;

endmodule

// File: tb/tb_tc_control_unit.sv
// Scoreboard bench for tc_control_unit: stimulus queues per-cycle expectations
// and row completions; a negedge monitor pops and compares them.
module tb_tc_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic       compute_en;
    logic [3:0] ptr_m, ptr_n, ptr_k;
    logic       out_valid;
    logic [3:0] row_out;

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] n;
        logic [3:0] k;
        logic       ov;
        logic [3:0] row;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] row_q[$];
    logic [3:0] row_hold;
    logic       done;
    logic       prev_ov;
    int         checks;
    int         errors;

    tc_control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .compute_en(compute_en),
        .ptr_m     (ptr_m),
        .ptr_n     (ptr_n),
        .ptr_k     (ptr_k),
        .out_valid (out_valid),
        .row_out   (row_out)
    );

    always #5 clk = ~clk;

    task automatic push(input int m, input int n, input int k, input logic ov, input int row);
        exp_t e;
        if (ov) begin
            row_hold = 4'(row);
            row_q.push_back(4'(row));
        end
        e.m = 4'(m); e.n = 4'(n); e.k = 4'(k); e.ov = ov; e.row = row_hold;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic ld, input logic cp);
        @(negedge clk);
        load_en    = ld;
        compute_en = cp;
        @(posedge clk);
        #1;
    endtask

    // Expects to be entered in walk cycle 0 (first COMPUTE cycle).
    task automatic walk(input int inj, input int rst_at);
        for (int c = 0; c < 256; c++) begin
            if (c == rst_at) begin
                reset    = 1'b0;
                row_hold = 4'd0;
                push(0, 0, 0, 1'b0, 0);
                @(posedge clk); #1;
                push(0, 0, 0, 1'b0, 0);
                @(negedge clk);
                reset      = 1'b1;
                load_en    = 1'b0;
                compute_en = 1'b0;
                @(posedge clk); #1;
                push(0, 0, 0, 1'b0, 0);
                for (int i = 0; i < 20; i++) begin
                    cycle(1'b0, 1'b0);
                    push(0, 0, 0, 1'b0, 0);
                end
                return;
            end
            push(c / 16, (c / 4) % 4, c % 4, (c % 16 == 0) && (c > 0), c / 16 - 1);
            cycle(c == inj, c == inj);
        end
        push(0, 0, 0, 1'b1, 15);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 3;
            if ({ptr_m, ptr_n, ptr_k} !== {e.m, e.n, e.k}) begin
                errors++;
                $display("FAIL ptrs t=%0t got (%0d,%0d,%0d) exp (%0d,%0d,%0d)",
                         $time, ptr_m, ptr_n, ptr_k, e.m, e.n, e.k);
            end
            if (out_valid !== e.ov) begin
                errors++;
                $display("FAIL out_valid t=%0t got %0b exp %0b", $time, out_valid, e.ov);
            end
            if (row_out !== e.row) begin
                errors++;
                $display("FAIL row_out_hold t=%0t got %0d exp %0d", $time, row_out, e.row);
            end
        end
        if (out_valid === 1'b1) begin
            checks += 2;
            if (row_q.size() == 0) begin
                errors++;
                $display("FAIL row_pulse t=%0t got row %0d exp no pulse", $time, row_out);
            end else begin
                logic [3:0] r;
                r = row_q.pop_front();
                if (row_out !== r) begin
                    errors++;
                    $display("FAIL row_pulse t=%0t got %0d exp %0d", $time, row_out, r);
                end
            end
            if (prev_ov === 1'b1) begin
                errors++;
                $display("FAIL ov_double t=%0t got 2 consecutive pulses exp 1", $time);
            end
        end
        prev_ov = out_valid;
        if (done) begin
            checks += 2;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL exp_drain got %0d left exp 0", exp_q.size());
            end
            if (row_q.size() != 0) begin
                errors++;
                $display("FAIL row_drain got %0d left exp 0", row_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        done       = 1'b0;
        prev_ov    = 1'b0;
        row_hold   = 4'd0;
        reset      = 1'b0;
        load_en    = 1'($urandom_range(0, 1));
        compute_en = 1'($urandom_range(0, 1));
        // Reset held with random control inputs.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            push(0, 0, 0, 1'b0, 0);
            load_en    = 1'($urandom_range(0, 1));
            compute_en = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        reset      = 1'b1;
        load_en    = 1'b0;
        compute_en = 1'b0;
        @(posedge clk); #1;
        push(0, 0, 0, 1'b0, 0);

        // Load for two cycles, back to IDLE, then start walk 1.
        cycle(1'b1, 1'b0); push(0, 0, 0, 1'b0, 0);
        cycle(1'b1, 1'b0); push(0, 0, 0, 1'b0, 0);
        cycle(1'b0, 1'b0); push(0, 0, 0, 1'b0, 0);
        cycle(1'b0, 1'b1);
        walk(-1, -1);

        // Back-to-back walk 2 from the final-pulse cycle, with ignored inputs at cycle 50.
        cycle(1'b0, 1'b1);
        walk(50, -1);
        cycle(1'b0, 1'b0); push(0, 0, 0, 1'b0, 0);

        // Simultaneous load/compute in IDLE: load wins, compute ignored in LOAD.
        cycle(1'b1, 1'b1); push(0, 0, 0, 1'b0, 0);
        cycle(1'b1, 1'b1); push(0, 0, 0, 1'b0, 0);
        cycle(1'b0, 1'b0); push(0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0);
            push(0, 0, 0, 1'b0, 0);
        end

        // Walk 3 aborted by asynchronous reset at cycle 100.
        cycle(1'b0, 1'b1);
        walk(-1, 100);

        @(negedge clk);
        done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no summary exp finish");
        $fatal(1, "timeout");
    end

endmodule
